// File: rtl/pixel_mem_reader.sv
// Read-side master for the pixel data memory: sequential single-word reads,
// one-cycle read latency absorbed into a small FIFO, valid/ready stream out.
module pixel_mem_reader #(
   parameter int MEMORY_ADDR_SIZE = 10,
   parameter int MEMORY_DATA_SIZE = 16,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [MEMORY_ADDR_SIZE-1:0]   baseAddr,
   input  logic [MEMORY_ADDR_SIZE:0]     length,
   output logic                          busy,
   output logic                          done,
   output logic                          memReadEn,
   output logic [MEMORY_ADDR_SIZE-1:0]   memAddress,
   input  logic [MEMORY_DATA_SIZE-1:0]   memDataIn,
   output logic                          outValid,
   output logic [MEMORY_DATA_SIZE-1:0]   outData,
   output logic                          outLast,
   input  logic                          outReady
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [MEMORY_ADDR_SIZE:0]   LEN_ONE  = (MEMORY_ADDR_SIZE+1)'(1);
   localparam logic [MEMORY_ADDR_SIZE-1:0] ADDR_ONE = MEMORY_ADDR_SIZE'(1);
   localparam logic [CW-1:0]               CNT_ONE  = CW'(1);
   localparam logic [CW:0]                 DEPTH_C  = (CW+1)'(FIFO_DEPTH);
   localparam logic [PW-1:0]               PTR_ONE  = PW'(1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                         state_reg, state_next;
   logic                           rd_en_reg, rd_en_next;
   logic [MEMORY_ADDR_SIZE-1:0]    addr_reg, addr_next;
   logic [MEMORY_ADDR_SIZE:0]      remaining_reg, remaining_next;
   logic                           issue_last_reg, issue_last_next;
   logic                           cap_valid_reg, cap_last_reg;

   logic [MEMORY_DATA_SIZE-1:0]    fifo_data [FIFO_DEPTH];
   logic                           fifo_last [FIFO_DEPTH];
   logic [PW-1:0]                  wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]                  count_reg, count_next;

   logic                           push, pop, in_flight_zero, has_space;
   logic [CW:0]                    occupancy;

   assign push = cap_valid_reg;
   assign pop  = outValid && outReady;

   // Occupancy counts words already buffered plus reads whose data is still on its way.
   assign occupancy      = {1'b0, count_reg} + (CW+1)'(rd_en_reg) + (CW+1)'(cap_valid_reg);
   assign has_space      = occupancy < DEPTH_C;
   assign in_flight_zero = !rd_en_reg && !cap_valid_reg;

   always_comb begin
      state_next      = state_reg;
      rd_en_next      = 1'b0;
      addr_next       = addr_reg;
      remaining_next  = remaining_reg;
      issue_last_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_next      = READ;
                  rd_en_next      = 1'b1;
                  addr_next       = baseAddr;
                  remaining_next  = length - LEN_ONE;
                  issue_last_next = (length == LEN_ONE);
               end else begin
                  state_next = DONE;
               end
            end
         end
         READ: begin
            if (remaining_reg == '0) begin
               state_next = DRAIN;
            end else if (has_space) begin
               rd_en_next      = 1'b1;
               addr_next       = addr_reg + ADDR_ONE;
               remaining_next  = remaining_reg - LEN_ONE;
               issue_last_next = (remaining_reg == LEN_ONE);
               if (remaining_reg == LEN_ONE)
                  state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Leave on the edge that pops the final word, so DONE follows immediately.
            if (in_flight_zero && (count_reg == '0 || (count_reg == CNT_ONE && pop)))
               state_next = DONE;
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + CNT_ONE;
      else if (pop && !push)
         count_next = count_reg - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         rd_en_reg      <= 1'b0;
         addr_reg       <= '0;
         remaining_reg  <= '0;
         issue_last_reg <= 1'b0;
         cap_valid_reg  <= 1'b0;
         cap_last_reg   <= 1'b0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         rd_en_reg      <= rd_en_next;
         addr_reg       <= addr_next;
         remaining_reg  <= remaining_next;
         issue_last_reg <= issue_last_next;
         cap_valid_reg  <= rd_en_reg;
         cap_last_reg   <= rd_en_reg && issue_last_reg;
         count_reg      <= count_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

   // Storage is not reset; entries are only visible through count_reg.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr_reg] <= memDataIn;
         fifo_last[wr_ptr_reg] <= cap_last_reg;
      end
   end

   assign busy       = (state_reg != IDLE);
   assign done       = (state_reg == DONE);
   assign memReadEn  = rd_en_reg;
   assign memAddress = addr_reg;
   assign outValid   = (count_reg != '0);
   assign outData    = outValid ? fifo_data[rd_ptr_reg] : '0;
   assign outLast    = outValid && fifo_last[rd_ptr_reg];

endmodule

// File: tb/tb_pixel_mem_reader.sv
// Directed bench for pixel_mem_reader with a registered-read memory model
// and a negedge monitor that logs addresses, pops and done pulses.
module tb_pixel_mem_reader;

   localparam int AW    = 10;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] baseAddr = '0;
   logic [AW:0]   length = '0;
   logic          busy, done, memReadEn, outValid, outLast;
   logic [AW-1:0] memAddress;
   logic [DW-1:0] memDataIn = '0;
   logic [DW-1:0] outData;
   logic          outReady = 1'b0;

   int compared = 0;
   int mismatched = 0;

   pixel_mem_reader #(
      .MEMORY_ADDR_SIZE(AW),
      .MEMORY_DATA_SIZE(DW),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .length(length),
      .busy(busy), .done(done), .memReadEn(memReadEn), .memAddress(memAddress),
      .memDataIn(memDataIn), .outValid(outValid), .outData(outData),
      .outLast(outLast), .outReady(outReady)
   );

   always #5 clk = ~clk;

   // Memory word i holds 0x1000+i; data appears the cycle after the read strobe.
   logic [DW-1:0] mem [1 << AW];
   initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(16'h1000 + i);
   always @(posedge clk) if (memReadEn) memDataIn <= mem[memAddress];

   int            cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [AW-1:0] addr_q[$];
   logic [DW-1:0] data_q[$];
   logic          last_q[$];
   int            pop_cyc[$];
   int            done_cnt, done_cyc, issued, popped, max_out, start_cyc;
   logic          valid_seen;

   always @(negedge clk) begin
      if (memReadEn) begin
         addr_q.push_back(memAddress);
         issued++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (outValid && outReady) begin
         data_q.push_back(outData);
         last_q.push_back(outLast);
         pop_cyc.push_back(cyc);
         popped++;
      end
      if (outValid) valid_seen = 1'b1;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      addr_q.delete(); data_q.delete(); last_q.delete(); pop_cyc.delete();
      done_cnt = 0; done_cyc = 0; issued = 0; popped = 0; max_out = 0;
      valid_seen = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] n);
      step();
      start = 1'b1; baseAddr = b; length = n; start_cyc = cyc;
      step();
      start = 1'b0;
   endtask

   // mode 0: outReady held high; mode 1: outReady pattern 1,0,0,1 repeating.
   task automatic run_until_done(input int max_cyc, input int mode);
      for (int i = 0; i < max_cyc && done_cnt == 0; i++) begin
         step();
         outReady = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      end
      step();
      step();
      outReady = 1'b1;
   endtask

   initial begin
      clear_log();
      start_cyc = 0;
      #1 rst = 1'b0;
      #2;
      check("reset_outputs", {1'b0, busy, done, memReadEn, memAddress, outValid, outData, outLast}, 32'h0);
      repeat (3) step();
      rst = 1'b1;
      step();

      // Basic transfer
      clear_log();
      outReady = 1'b1;
      pulse_start(10'h010, 11'd4);
      @(negedge clk);
      check("basic_cycle1", {29'd0, busy, memReadEn, 1'b0}, {29'd0, 1'b1, 1'b1, 1'b0});
      check("basic_first_addr", 32'(memAddress), 32'h010);
      run_until_done(40, 0);
      check("basic_done_cnt", done_cnt, 1);
      check("basic_done_time", done_cyc - start_cyc, 7);
      check("basic_words", data_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("basic_data%0d", i), 32'(data_q[i]), 32'h1010 + i);
         check($sformatf("basic_last%0d", i), 32'(last_q[i]), (i == 3) ? 32'd1 : 32'd0);
      end
      check("basic_first_pop", pop_cyc[0] - start_cyc, 3);
      check("basic_consecutive", pop_cyc[3] - pop_cyc[0], 3);
      check("basic_idle_after", {31'd0, busy}, 32'd0);

      // Backpressure
      clear_log();
      pulse_start(10'h020, 11'd8);
      run_until_done(80, 1);
      check("bp_done_cnt", done_cnt, 1);
      check("bp_words", data_q.size(), 8);
      for (int i = 0; i < 8; i++)
         check($sformatf("bp_data%0d", i), 32'(data_q[i]), 32'h1020 + i);
      check("bp_last7", 32'(last_q[7]), 32'd1);
      check("bp_last6", 32'(last_q[6]), 32'd0);
      check("bp_no_overflow", (max_out <= DEPTH) ? 32'd1 : 32'd0, 32'd1);

      // Address wrap
      clear_log();
      pulse_start(10'h3FE, 11'd4);
      run_until_done(40, 0);
      check("wrap_reads", addr_q.size(), 4);
      check("wrap_addr0", 32'(addr_q[0]), 32'h3FE);
      check("wrap_addr1", 32'(addr_q[1]), 32'h3FF);
      check("wrap_addr2", 32'(addr_q[2]), 32'h000);
      check("wrap_addr3", 32'(addr_q[3]), 32'h001);
      check("wrap_data2", 32'(data_q[2]), 32'h1000);
      check("wrap_last3", 32'(last_q[3]), 32'd1);

      // Zero length
      clear_log();
      pulse_start(10'h123, 11'd0);
      @(negedge clk);
      check("zero_cycle1", {29'd0, busy, done, memReadEn}, {29'd0, 1'b1, 1'b1, 1'b0});
      @(negedge clk);
      check("zero_cycle2", {30'd0, busy, done}, 32'd0);
      step();
      check("zero_no_reads", addr_q.size(), 0);
      check("zero_no_valid", {31'd0, valid_seen}, 32'd0);
      check("zero_done_cnt", done_cnt, 1);

      // Start while busy
      clear_log();
      pulse_start(10'h040, 11'd5);
      step();
      start = 1'b1; baseAddr = 10'h100; length = 11'd2;
      step();
      start = 1'b0;
      run_until_done(40, 0);
      check("busy_start_done", done_cnt, 1);
      check("busy_start_reads", addr_q.size(), 5);
      check("busy_start_words", data_q.size(), 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("busy_start_data%0d", i), 32'(data_q[i]), 32'h1040 + i);
      check("busy_start_last", 32'(last_q[4]), 32'd1);

      // Asynchronous reset mid-transfer with a full FIFO
      clear_log();
      outReady = 1'b0;
      pulse_start(10'h080, 11'd16);
      repeat (8) step();
      check("rst_fifo_full", {30'd0, outValid, memReadEn}, {30'd0, 1'b1, 1'b0});
      check("rst_busy_before", {31'd0, busy}, 32'd1);
      #1 rst = 1'b0;
      #1;
      check("rst_outputs_zero", {1'b0, busy, done, memReadEn, memAddress, outValid, outData, outLast}, 32'h0);
      repeat (3) step();
      rst = 1'b1;
      repeat (3) step();
      check("rst_no_done", done_cnt, 0);
      clear_log();
      outReady = 1'b1;
      pulse_start(10'h000, 11'd2);
      run_until_done(40, 0);
      check("rst_fresh_done", done_cnt, 1);
      check("rst_fresh_words", data_q.size(), 2);
      check("rst_fresh_data0", 32'(data_q[0]), 32'h1000);
      check("rst_fresh_data1", 32'(data_q[1]), 32'h1001);
      check("rst_fresh_last", 32'(last_q[1]), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
